// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_W payload bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to build in the parity bit; otherwise PAR_EN/PAR_ODD are ignored.
module uart_tx_framer #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  input  logic              PAR_EN,
  input  logic              PAR_ODD,
  output logic              TX_BUSY,
  output logic              TX_DONE,
  output logic              TXD
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_W);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_e;
`endif

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                stop_q, stop_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                txd_q, txd_d;
  logic                done_q, done_d;
  logic                bit_end;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
`else
  logic unused_par;
  assign unused_par = PAR_EN ^ PAR_ODD;
`endif

  assign bit_end  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign TX_READY = (state_q == S_IDLE);
  assign TX_BUSY  = ~TX_READY;
  assign TX_DONE  = done_q;
  assign TXD      = txd_q;

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      stop_q    <= 1'b0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  // Next-state and next-output logic; the bit counter restarts at every bit boundary
  always_comb begin
    state_d   = state_q;
    cnt_d     = bit_end ? '0 : cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    stop_d    = stop_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        txd_d = 1'b1;
        if (TX_VALID) begin
          state_d   = S_START;
          txd_d     = 1'b0;
          shift_d   = TX_DATA;
          idx_d     = '0;
          stop_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_en_d  = PAR_EN;
          par_bit_d = (^TX_DATA) ^ PAR_ODD;
`endif
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = S_PARITY;
              txd_d   = par_bit_q;
            end
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
`endif

      S_STOP: begin
        txd_d = 1'b1;
        if (bit_end) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: two configurations (8/4/1 and 5/1/2) checked cycle by cycle
// against a frame model built as a queue of line levels.
module tb_uart_tx_framer;

  localparam int unsigned DW0 = 8, CPB0 = 4, SB0 = 1;
  localparam int unsigned DW1 = 5, CPB1 = 1, SB1 = 2;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] tx_data0;
  logic [4:0] tx_data1;
  logic [1:0] tx_valid, par_en, par_odd;
  logic       ready0, busy0, done0, txd0;
  logic       ready1, busy1, done1, txd1;
  wire  [1:0] tx_ready = {ready1, ready0};
  wire  [1:0] tx_busy  = {busy1, busy0};
  wire  [1:0] tx_done  = {done1, done0};
  wire  [1:0] txd      = {txd1, txd0};

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int prev_acc = 0;
  int prev_n = 0;
  bit prev_chain = 1'b0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  uart_tx_framer #(.DATA_W(DW0), .CLKS_PER_BIT(CPB0), .STOP_BITS(SB0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .TX_DATA(tx_data0), .TX_VALID(tx_valid[0]),
    .TX_READY(ready0), .PAR_EN(par_en[0]), .PAR_ODD(par_odd[0]),
    .TX_BUSY(busy0), .TX_DONE(done0), .TXD(txd0)
  );

  uart_tx_framer #(.DATA_W(DW1), .CLKS_PER_BIT(CPB1), .STOP_BITS(SB1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .TX_DATA(tx_data1), .TX_VALID(tx_valid[1]),
    .TX_READY(ready1), .PAR_EN(par_en[1]), .PAR_ODD(par_odd[1]),
    .TX_BUSY(busy1), .TX_DONE(done1), .TXD(txd1)
  );

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d @cyc %0d: observed %0h expected %0h", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic [8:0] data, input logic pen, input logic podd,
                       input logic v);
    if (d == 0) tx_data0 = data[7:0];
    else        tx_data1 = data[4:0];
    tx_valid[d] = v;
    par_en[d]   = pen;
    par_odd[d]  = podd;
  endtask

  // Expects a request already driven at the current negedge with the DUT idle.
  task automatic run_frame(input int d, input logic [8:0] data, input logic pen, input logic podd,
                           input bit chain, input logic [8:0] ndata, input logic npen,
                           input logic npodd);
    logic       bits[$];
    int         dw, c, sb, n, acc;
    logic [8:0] mask;
    dw   = (d == 0) ? DW0 : DW1;
    c    = (d == 0) ? CPB0 : CPB1;
    sb   = (d == 0) ? SB0 : SB1;
    mask = 9'((1 << dw) - 1);
    bits.push_back(1'b0);
    for (int i = 0; i < dw; i++) bits.push_back(data[i]);
`ifdef UART_TX_PARITY_EN
    if (pen) bits.push_back((^(data & mask)) ^ podd);
`else
    if (pen && podd && (mask == 9'h0)) bits.push_back(1'b0);
`endif
    for (int i = 0; i < sb; i++) bits.push_back(1'b1);
    n = bits.size() * c;

    chk("ready_before_accept", d, 32'(tx_ready[d]), 32'd1);
    @(posedge CLK);
    acc = cyc;
    if (prev_chain) chk("back_to_back_start_gap", d, 32'(acc - prev_acc), 32'(prev_n + 1));
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      chk("txd", d, 32'(txd[d]), 32'(bits[k / c]));
      chk("busy", d, 32'(tx_busy[d]), 32'd1);
      chk("done_early", d, 32'(tx_done[d]), 32'd0);
      drive(d, ~data, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
    end
    @(negedge CLK);
    chk("done_pulse", d, 32'(tx_done[d]), 32'd1);
    chk("txd_idle_gap", d, 32'(txd[d]), 32'd1);
    chk("ready_at_done", d, 32'(tx_ready[d]), 32'd1);
    prev_chain = chain;
    prev_acc   = acc;
    prev_n     = n;
    if (chain) begin
      drive(d, ndata, npen, npodd, 1'b1);
    end else begin
      drive(d, data, 1'b0, 1'b0, 1'b0);
      @(negedge CLK);
      chk("done_one_cycle", d, 32'(tx_done[d]), 32'd0);
      chk("txd_idle", d, 32'(txd[d]), 32'd1);
    end
  endtask

  initial begin
    logic [8:0] data, ndata;
    logic       pen, podd, npen, npodd;
    bit         chain;

    RST_N = 1'b0;
    drive(0, 9'h0, 1'b0, 1'b0, 1'b0);
    drive(1, 9'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      chk("rst_txd", d, 32'(txd[d]), 32'd1);
      chk("rst_ready", d, 32'(tx_ready[d]), 32'd1);
      chk("rst_busy", d, 32'(tx_busy[d]), 32'd0);
      chk("rst_done", d, 32'(tx_done[d]), 32'd0);
    end
    RST_N = 1'b1;
    @(negedge CLK);

    // 0xA5 without parity, then with even and odd parity requested
    drive(0, 9'h0A5, 1'b0, 1'b0, 1'b1);
    run_frame(0, 9'h0A5, 1'b0, 1'b0, 1'b0, 9'h0, 1'b0, 1'b0);
    drive(0, 9'h0A5, 1'b1, 1'b0, 1'b1);
    run_frame(0, 9'h0A5, 1'b1, 1'b0, 1'b0, 9'h0, 1'b0, 1'b0);
    drive(0, 9'h0A5, 1'b1, 1'b1, 1'b1);
    run_frame(0, 9'h0A5, 1'b1, 1'b1, 1'b0, 9'h0, 1'b0, 1'b0);

    // Back-to-back 0x00 then 0xFF; payload inputs flip to ~data while busy
    drive(0, 9'h000, 1'b0, 1'b0, 1'b1);
    run_frame(0, 9'h000, 1'b0, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b0);
    run_frame(0, 9'h0FF, 1'b0, 1'b0, 1'b0, 9'h0, 1'b0, 1'b0);

    // One cycle per bit, two stop bits, 5-bit payload
    drive(1, 9'h015, 1'b0, 1'b0, 1'b1);
    run_frame(1, 9'h015, 1'b0, 1'b0, 1'b0, 9'h0, 1'b0, 1'b0);

    // Reset ten cycles into a frame
    drive(0, 9'h03C, 1'b0, 1'b0, 1'b1);
    @(posedge CLK);
    @(negedge CLK);
    drive(0, 9'h03C, 1'b0, 1'b0, 1'b0);
    repeat (9) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("async_rst_txd", 0, 32'(txd[0]), 32'd1);
    chk("async_rst_ready", 0, 32'(tx_ready[0]), 32'd1);
    chk("async_rst_busy", 0, 32'(tx_busy[0]), 32'd0);
    chk("async_rst_done", 0, 32'(tx_done[0]), 32'd0);
    repeat (3) begin
      @(negedge CLK);
      chk("rst_hold_done", 0, 32'(tx_done[0]), 32'd0);
      chk("rst_hold_txd", 0, 32'(txd[0]), 32'd1);
    end
    RST_N = 1'b1;
    prev_chain = 1'b0;
    drive(0, 9'h0C3, 1'b0, 1'b0, 1'b1);
    run_frame(0, 9'h0C3, 1'b0, 1'b0, 1'b0, 9'h0, 1'b0, 1'b0);

    // Random frames on both configurations, with random back-to-back chaining
    for (int d = 0; d < 2; d++) begin
      prev_chain = 1'b0;
      data = 9'($urandom);
      pen  = 1'($urandom % 2);
      podd = 1'($urandom % 2);
      drive(d, data, pen, podd, 1'b1);
      for (int i = 0; i < 12; i++) begin
        chain = (i < 11) && ($urandom % 2 == 1);
        ndata = 9'($urandom);
        npen  = 1'($urandom % 2);
        npodd = 1'($urandom % 2);
        run_frame(d, data, pen, podd, chain, ndata, npen, npodd);
        if (chain) begin
          data = ndata; pen = npen; podd = npodd;
        end else if (i < 11) begin
          data = 9'($urandom);
          pen  = 1'($urandom % 2);
          podd = 1'($urandom % 2);
          prev_chain = 1'b0;
          drive(d, data, pen, podd, 1'b1);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per frame; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 16, CLK cycles per serial bit; legal range >=1.
REQ-003 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-004 Port: CLK  input  1  single clock; all state on rising edge.
REQ-005 Port: RST_N  input  1  reset, asynchronous, active-low.
REQ-006 Port: TX_DATA  input  DATA_W  payload, sampled only at acceptance.
REQ-007 Port: TX_VALID  input  1  request to send TX_DATA.
REQ-008 Port: TX_READY  output  1  block can accept a frame this cycle.
REQ-009 Port: PAR_EN  input  1  parity bit enable, sampled at acceptance.
REQ-010 Port: PAR_ODD  input  1  1 = odd parity, 0 = even, sampled at acceptance.
REQ-011 Port: TX_BUSY  output  1  frame in progress.
REQ-012 Port: TX_DONE  output  1  one-cycle pulse at frame completion.
REQ-013 Port: TXD  output  1  serial line, registered, idle high.

Function
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; TX_READY = (state==IDLE); TX_BUSY = !TX_READY.
REQ-015 Acceptance SHALL occur on a rising edge with TX_VALID & TX_READY: TX_DATA, PAR_EN, PAR_ODD latched, state->START, TXD<=0 at that same edge.
REQ-016 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a bit counter of width max(1,$clog2(CLKS_PER_BIT)) reset at every bit boundary.
REQ-017 DATA SHALL send TX_DATA LSB first, DATA_W bits, via a shift register.
REQ-018 PARITY state SHALL be entered only when parity is compiled in and latched PAR_EN=1; bit = XOR(data) for even, ~XOR(data) for odd.
REQ-019 STOP SHALL drive TXD=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-020 Frame length SHALL be (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT cycles, P=1 if parity bit sent else 0.
REQ-021 At the edge ending the last stop bit: state->IDLE, TX_DONE=1 for that one cycle, TXD stays 1.
REQ-022 TX_VALID asserted in the TX_DONE cycle SHALL be accepted at the next edge; minimum inter-frame gap is one idle-high cycle.
REQ-023 TX_VALID, TX_DATA, PAR_EN, PAR_ODD changes while TX_BUSY=1 SHALL have no effect on the frame in progress.
REQ-024 CLKS_PER_BIT=1 SHALL produce one TXD bit per cycle without counter wrap errors.

Reset
REQ-025 RST_N=0 SHALL immediately force state IDLE, TXD=1, TX_READY=1, TX_BUSY=0, TX_DONE=0, counters and shift register 0.
REQ-026 Reset mid-frame SHALL abort without a TX_DONE pulse; first acceptance is possible on the first edge after RST_N rises.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: parity per REQ-018 available.
REQ-028 Macro UART_TX_PARITY_EN undefined: PARITY state and logic absent, PAR_EN/PAR_ODD ports present but ignored, P=0 always.

Verification
REQ-029 DATA_W=8, CLKS_PER_BIT=4, no parity, send 0xA5 -> TXD 0,1,0,1,0,0,1,0,1,1 each 4 cycles, TX_DONE on cycle 40 after acceptance.
REQ-030 Macro defined, PAR_EN=1, 0xA5: PAR_ODD=0 -> parity bit 0; PAR_ODD=1 -> parity bit 1; frame 44 cycles.
REQ-031 TX_VALID held high, data 0x00 then 0xFF, CLKS_PER_BIT=4 -> second start bit begins 41 cycles after first, exactly one idle-high cycle between.
REQ-032 RST_N low 10 cycles into frame -> TXD=1 and TX_READY=1 asynchronously, no TX_DONE, next frame correct.
REQ-033 STOP_BITS=2, CLKS_PER_BIT=1, DATA_W=5, 0x15 -> TXD 0,1,0,1,0,1,1,1, TX_DONE after 8 cycles.
REQ-034 TX_DATA changed to 0x00 mid-frame after sending 0xFF -> transmitted payload remains 0xFF.
